// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock/tick divider.
// Optional feature macro: CLKDIV_PHASE_EN (per-channel sync phase offset).
package clkdiv_pkg;

  localparam int CW_DEF  = 16;
  localparam int CW_MAX  = 32;
  localparam int NCH_MAX = 16;

  typedef logic [3:0]        chan_idx_t;
  typedef logic [CW_MAX-1:0] cval_t;

  localparam cval_t CVAL_ZERO = {CW_MAX{1'b0}};
  localparam cval_t CVAL_ONE  = {{(CW_MAX-1){1'b0}}, 1'b1};

  // Channel state is held at the widest supported width; bits above CW stay
  // zero because every loaded value is zero-extended from CW bits.
  typedef struct packed {
    cval_t cnt;
    cval_t div;
    cval_t shadow;
    logic  pend;
    cval_t ph;
  } chan_state_t;

  // Width of the channel select bus; a single channel still gets one bit.
  function automatic int sel_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  // Unsigned minimum, used to clamp a phase offset to the applied divisor.
  function automatic cval_t cval_min(input cval_t a, input cval_t b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Control/status bundle of the divider. master = controller, slave = divider.
// Optional feature macro: CLKDIV_PHASE_EN adds the div_ph bus.
interface clkdiv_if import clkdiv_pkg::*; #(
  parameter int NCH = 2,
  parameter int CW  = CW_DEF
) ();

  localparam int SELW = sel_w(NCH);

  logic [NCH-1:0]  en;
  logic            sync;
  logic            div_wr;
  logic [SELW-1:0] div_sel;
  logic [CW-1:0]   div_val;
`ifdef CLKDIV_PHASE_EN
  logic [CW-1:0]   div_ph;
`endif
  logic [NCH-1:0]  div_pend;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  tick;

  modport master (
    output en, sync, div_wr, div_sel, div_val,
`ifdef CLKDIV_PHASE_EN
    output div_ph,
`endif
    input  div_pend, clk_out, tick
  );

  modport slave (
    input  en, sync, div_wr, div_sel, div_val,
`ifdef CLKDIV_PHASE_EN
    input  div_ph,
`endif
    output div_pend, clk_out, tick
  );

endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, shadow divisor with deferred apply, and
// registered toggle/tick outputs.
// Optional feature macro: CLKDIV_PHASE_EN (sync loads cnt from the phase register).
module clkdiv_chan import clkdiv_pkg::*; #(
  parameter int          CW      = CW_DEF,
  parameter int unsigned DEF_DIV = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] wr_val,
`ifdef CLKDIV_PHASE_EN
  input  logic [CW-1:0] wr_ph,
`endif
  output logic          pend,
  output logic          clk_out,
  output logic          tick
);

  localparam cval_t DEF_V = cval_t'(DEF_DIV);
  localparam chan_state_t RST_ST = '{cnt: CVAL_ZERO, div: DEF_V, shadow: DEF_V,
                                     pend: 1'b0, ph: CVAL_ZERO};

  chan_state_t st_q, st_d;
  logic        clk_out_q, clk_out_d;
  logic        tick_q, tick_d;
  cval_t       app_div_s;

  // Next state: sync beats enable; a write is merged last so it lands after any apply.
  always_comb begin
    st_d      = st_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    app_div_s = st_q.pend ? st_q.shadow : st_q.div;
    if (sync) begin
      st_d.div  = app_div_s;
      st_d.pend = 1'b0;
      clk_out_d = 1'b0;
`ifdef CLKDIV_PHASE_EN
      st_d.cnt  = cval_min(st_q.ph, app_div_s);
`else
      st_d.cnt  = CVAL_ZERO;
`endif
    end else if (en) begin
      if (st_q.cnt == st_q.div) begin
        // Terminal count runs on the old divisor; the shadow takes over afterwards.
        st_d.cnt  = CVAL_ZERO;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
        st_d.div  = app_div_s;
        st_d.pend = 1'b0;
      end else begin
        st_d.cnt  = st_q.cnt + CVAL_ONE;
      end
    end else begin
      st_d.cnt = st_q.cnt;
    end
    if (wr) begin
      st_d.shadow = cval_t'(wr_val);
      st_d.pend   = 1'b1;
`ifdef CLKDIV_PHASE_EN
      st_d.ph     = cval_t'(wr_ph);
`endif
    end else begin
      st_d.shadow = st_q.shadow;
    end
`ifndef CLKDIV_PHASE_EN
    st_d.ph = CVAL_ZERO;
`endif
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= RST_ST;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pend    = st_q.pend;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock/tick divider top: decodes the divisor write select and
// fans the global sync strobe out to NCH independent channels.
// Optional feature macro: CLKDIV_PHASE_EN (phase-staggered restart on sync).
module clkdiv_multi import clkdiv_pkg::*; #(
  parameter int          NCH     = 2,
  parameter int          CW      = CW_DEF,
  parameter int unsigned DEF_DIV = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  clkdiv_if.slave  bus
);

  logic [NCH-1:0] wr_s;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    // Selects at or above NCH match no channel, so such writes are dropped.
    assign wr_s[g] = bus.div_wr & (chan_idx_t'(bus.div_sel) == chan_idx_t'(g));

    clkdiv_chan #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.en[g]),
      .sync    (bus.sync),
      .wr      (wr_s[g]),
      .wr_val  (bus.div_val),
`ifdef CLKDIV_PHASE_EN
      .wr_ph   (bus.div_ph),
`endif
      .pend    (bus.div_pend[g]),
      .clk_out (bus.clk_out[g]),
      .tick    (bus.tick[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: a behavioural channel model pushes the
// expected {tick, clk_out, div_pend} after every rising edge and each scenario
// pops and compares it on the following falling edge, plus directed checks.
module tb_clkdiv_multi;
  import clkdiv_pkg::*;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int DEF = 1;

  typedef logic [3*NCH-1:0] obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  clkdiv_if #(.NCH(NCH), .CW(CW)) bus ();

  clkdiv_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_run  = 0;
  int   n_fail = 0;
  obs_t exp_q[$];

  int m_cnt[NCH];
  int m_div[NCH];
  int m_sh[NCH];
  int m_ph[NCH];
  bit m_pend[NCH];
  bit m_clk[NCH];
  bit m_tick[NCH];

  function automatic obs_t observe();
    return {bus.tick, bus.clk_out, bus.div_pend};
  endfunction

  function automatic void model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_cnt[ch] = 0; m_div[ch] = DEF; m_sh[ch] = DEF; m_ph[ch] = 0;
      m_pend[ch] = 1'b0; m_clk[ch] = 1'b0; m_tick[ch] = 1'b0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_step();
    obs_t e;
    for (int ch = 0; ch < NCH; ch++) begin
      if (bus.sync) begin
        if (m_pend[ch]) m_div[ch] = m_sh[ch];
        m_pend[ch] = 1'b0; m_clk[ch] = 1'b0; m_tick[ch] = 1'b0;
`ifdef CLKDIV_PHASE_EN
        m_cnt[ch] = (m_ph[ch] < m_div[ch]) ? m_ph[ch] : m_div[ch];
`else
        m_cnt[ch] = 0;
`endif
      end else if (bus.en[ch]) begin
        if (m_cnt[ch] == m_div[ch]) begin
          m_tick[ch] = 1'b1; m_cnt[ch] = 0; m_clk[ch] = !m_clk[ch];
          if (m_pend[ch]) begin m_div[ch] = m_sh[ch]; m_pend[ch] = 1'b0; end
        end else begin
          m_tick[ch] = 1'b0; m_cnt[ch] = m_cnt[ch] + 1;
        end
      end else begin
        m_tick[ch] = 1'b0;
      end
      if (bus.div_wr && int'(bus.div_sel) == ch) begin
        m_sh[ch] = int'(bus.div_val); m_pend[ch] = 1'b1;
`ifdef CLKDIV_PHASE_EN
        m_ph[ch] = int'(bus.div_ph);
`endif
      end
      e[ch] = m_pend[ch]; e[NCH+ch] = m_clk[ch]; e[2*NCH+ch] = m_tick[ch];
    end
    exp_q.push_back(e);
  endfunction

  // One clock cycle: model advances on the rising edge, DUT is sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_wr(input bit w, input int sel, input int val, input int ph);
    bus.div_wr  = w;
    bus.div_sel = 2'(sel);
    bus.div_val = 16'(val);
`ifdef CLKDIV_PHASE_EN
    bus.div_ph  = 16'(ph);
`else
    if (ph < 0) bus.div_val = 16'(val);
`endif
  endtask

  task automatic test_reset();
    obs_t e;
    bus.en = '0; bus.sync = 1'b0; set_wr(1'b0, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    n_run++;
    if (observe() !== '0) begin n_fail++; $display("FAIL reset_state: got %b want 0", observe()); end
    rst_n = 1'b1; bus.en = '1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      e = exp_q.pop_front(); n_run++;
      if (observe() !== e) begin n_fail++; $display("FAIL reset_sb k=%0d: got %b want %b", k, observe(), e); end
      n_run++;
      if (bus.tick[0] !== (k % 2 == 0) || bus.clk_out[0] !== ((k / 2) % 2 == 1)) begin
        n_fail++; $display("FAIL reset_ch0 k=%0d: tick=%b clk=%b want tick=%0d clk=%0d",
                           k, bus.tick[0], bus.clk_out[0], (k % 2 == 0), ((k / 2) % 2));
      end
    end
  endtask

  task automatic test_div0();
    obs_t e;
    logic prev;
    set_wr(1'b1, 0, 0, 0);
    cyc();
    e = exp_q.pop_front(); n_run++;
    if (observe() !== e) begin n_fail++; $display("FAIL div0_wr: got %b want %b", observe(), e); end
    set_wr(1'b0, 0, 0, 0);
    prev = bus.clk_out[0];
    for (int k = 1; k <= 10; k++) begin
      cyc();
      e = exp_q.pop_front(); n_run++;
      if (observe() !== e) begin n_fail++; $display("FAIL div0_sb k=%0d: got %b want %b", k, observe(), e); end
      if (k >= 2) begin
        n_run++;
        if (bus.tick[0] !== 1'b1 || bus.clk_out[0] === prev) begin
          n_fail++; $display("FAIL div0_ch0 k=%0d: tick=%b clk=%b prev_clk=%b want tick=1 toggling",
                             k, bus.tick[0], bus.clk_out[0], prev);
        end
      end
      prev = bus.clk_out[0];
    end
  endtask

  task automatic test_runtime_change();
    obs_t e;
    int   tq[$];
    set_wr(1'b1, 1, 4, 0);
    cyc();
    e = exp_q.pop_front(); n_run++;
    if (observe() !== e) begin n_fail++; $display("FAIL rt_wr4: got %b want %b", observe(), e); end
    set_wr(1'b0, 0, 0, 0); bus.sync = 1'b1;
    cyc();
    e = exp_q.pop_front(); n_run++;
    if (observe() !== e) begin n_fail++; $display("FAIL rt_sync: got %b want %b", observe(), e); end
    bus.sync = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      cyc();
      e = exp_q.pop_front(); n_run++;
      if (observe() !== e) begin n_fail++; $display("FAIL rt_sb k=%0d: got %b want %b", k, observe(), e); end
      if (bus.tick[1] === 1'b1) tq.push_back(k);
      if (k >= 3 && k <= 5) begin
        n_run++;
        if (bus.div_pend[1] !== (k != 5)) begin
          n_fail++; $display("FAIL rt_pend k=%0d: got %b want %0d", k, bus.div_pend[1], (k != 5));
        end
      end
      if (k == 2) set_wr(1'b1, 1, 9, 0);
      else set_wr(1'b0, 0, 0, 0);
    end
    n_run++;
    if (tq.size() < 3 || tq[0] != 5 || tq[1] != 15 || tq[2] != 25) begin
      n_fail++; $display("FAIL rt_ticks: got %p want 5,15,25", tq);
    end
  endtask

  task automatic test_coincident_wr();
    obs_t e;
    int   tq[$];
    set_wr(1'b1, 0, 3, 0);
    cyc();
    e = exp_q.pop_front(); n_run++;
    if (observe() !== e) begin n_fail++; $display("FAIL co_wr3: got %b want %b", observe(), e); end
    set_wr(1'b0, 0, 0, 0); bus.sync = 1'b1;
    cyc();
    e = exp_q.pop_front(); n_run++;
    if (observe() !== e) begin n_fail++; $display("FAIL co_sync: got %b want %b", observe(), e); end
    bus.sync = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      e = exp_q.pop_front(); n_run++;
      if (observe() !== e) begin n_fail++; $display("FAIL co_sb k=%0d: got %b want %b", k, observe(), e); end
      if (bus.tick[0] === 1'b1) tq.push_back(k);
      if (k == 4 || k == 11) begin
        n_run++;
        if (bus.div_pend[0] !== (k == 4)) begin
          n_fail++; $display("FAIL co_pend k=%0d: got %b want %0d", k, bus.div_pend[0], (k == 4));
        end
      end
      if (k == 1) set_wr(1'b1, 0, 6, 0);
      else if (k == 3) set_wr(1'b1, 0, 2, 0);
      else set_wr(1'b0, 0, 0, 0);
    end
    n_run++;
    if (tq.size() != 3 || tq[0] != 4 || tq[1] != 11 || tq[2] != 14) begin
      n_fail++; $display("FAIL co_ticks: got %p want 4,11,14", tq);
    end
  endtask

  task automatic test_enable_hold();
    obs_t e;
    logic held;
    for (int k = 1; k <= 17; k++) begin
      if (k == 3) begin bus.en[0] = 1'b0; held = bus.clk_out[0]; end
      if (k == 10) bus.en[0] = 1'b1;
      cyc();
      e = exp_q.pop_front(); n_run++;
      if (observe() !== e) begin n_fail++; $display("FAIL en_sb k=%0d: got %b want %b", k, observe(), e); end
      if (k >= 3 && k <= 9) begin
        n_run++;
        if (bus.tick[0] !== 1'b0 || bus.clk_out[0] !== held) begin
          n_fail++; $display("FAIL en_hold k=%0d: tick=%b clk=%b want tick=0 clk=%b",
                             k, bus.tick[0], bus.clk_out[0], held);
        end
      end
    end
  endtask

  task automatic test_sync();
    obs_t e;
    int   first;
    int   want;
    set_wr(1'b1, 0, 5, 3);
    cyc();
    e = exp_q.pop_front(); n_run++;
    if (observe() !== e) begin n_fail++; $display("FAIL sy_wr: got %b want %b", observe(), e); end
    set_wr(1'b1, 1, 3, 0); bus.sync = 1'b1;
    cyc();
    e = exp_q.pop_front(); n_run++;
    if (observe() !== e) begin n_fail++; $display("FAIL sy_sb0: got %b want %b", observe(), e); end
    n_run++;
    if (bus.clk_out !== 3'b000 || bus.tick !== 3'b000 || bus.div_pend !== 3'b010) begin
      n_fail++; $display("FAIL sy_state: clk=%b tick=%b pend=%b want 000 000 010",
                         bus.clk_out, bus.tick, bus.div_pend);
    end
    set_wr(1'b0, 0, 0, 0); bus.sync = 1'b0;
    first = 0;
`ifdef CLKDIV_PHASE_EN
    want = 3;
`else
    want = 6;
`endif
    for (int k = 1; k <= 8; k++) begin
      cyc();
      e = exp_q.pop_front(); n_run++;
      if (observe() !== e) begin n_fail++; $display("FAIL sy_sb k=%0d: got %b want %b", k, observe(), e); end
      if (bus.tick[0] === 1'b1 && first == 0) first = k;
    end
    n_run++;
    if (first != want) begin n_fail++; $display("FAIL sy_first_tick: got %0d want %0d", first, want); end
  endtask

  task automatic test_async_reset();
    obs_t e;
    set_wr(1'b1, 2, 4, 0);
    cyc();
    e = exp_q.pop_front(); n_run++;
    if (observe() !== e) begin n_fail++; $display("FAIL ar_wr: got %b want %b", observe(), e); end
    set_wr(1'b0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (observe() !== '0) begin n_fail++; $display("FAIL ar_drop: got %b want 0", observe()); end
    model_reset();
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      e = exp_q.pop_front(); n_run++;
      if (observe() !== e) begin n_fail++; $display("FAIL ar_sb k=%0d: got %b want %b", k, observe(), e); end
      n_run++;
      if (bus.tick[0] !== (k % 2 == 0)) begin
        n_fail++; $display("FAIL ar_tick k=%0d: got %b want %0d", k, bus.tick[0], (k % 2 == 0));
      end
    end
  endtask

  task automatic test_bad_sel();
    obs_t e;
    set_wr(1'b1, 3, 7, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      set_wr(1'b0, 0, 0, 0);
      e = exp_q.pop_front(); n_run++;
      if (observe() !== e) begin n_fail++; $display("FAIL bs_sb k=%0d: got %b want %b", k, observe(), e); end
      n_run++;
      if (bus.div_pend !== 3'b000) begin n_fail++; $display("FAIL bs_pend k=%0d: got %b want 000", k, bus.div_pend); end
    end
  endtask

  initial begin
    test_reset();
    test_div0();
    test_runtime_change();
    test_coincident_wr();
    test_enable_hold();
    test_sync();
    test_async_reset();
    test_bad_sel();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
